// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction fetch stage.
// Holds the IF/ID bundle layout and fetch constants.
package if_stage_pkg;

  localparam int INSTR_W = 32;
  localparam int IMEM_AW = 7;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h8b1f03ff;

  typedef struct packed {
    logic               valid;
    logic [INSTR_W-1:0] instr;
  } if_id_t;

  localparam if_id_t IF_ID_BUBBLE = '{
    valid: 1'b0,
    instr: NOP_INSTR
  };

endpackage

// File: rtl/if_stage_pc_reg.sv
// Program counter register.
// Load takes priority over the enabled update.
module pc_reg #(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         load,
  input  logic [N-1:0] load_val,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  // PC state: redirect load first, then enabled advance
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage with IF/ID register.
// Redirects win over stalls and always bubble IF/ID.
import if_stage_pkg::*;

module if_stage #(
  parameter int N = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               flush,
  input  logic               pcsrc,
  input  logic [N-1:0]       pcbranch,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [INSTR_W-1:0] imem_q,
  output logic [N-1:0]       pc_d,
  output logic [INSTR_W-1:0] instr_d,
  output logic               valid_d,
  output logic [15:0]        fetch_count
);

  logic [N-1:0] pc;
  logic [N-1:0] pc_seq;
  logic [N-1:0] pc_tgt;
  logic         load_ok;
  if_id_t       if_id;

  assign pc_seq  = pc + N'(4);
  assign pc_tgt  = pcbranch & ~N'(3);
  assign load_ok = ~flush & ~pcsrc & ~stall;

  pc_reg #(
    .N(N)
  ) u_pc (
    .clk     (clk),
    .reset   (reset),
    .en      (~stall),
    .load    (pcsrc),
    .load_val(pc_tgt),
    .d       (pc_seq),
    .q       (pc)
  );

  assign imem_addr = pc[IMEM_AW+1:2];

  // IF/ID register: bubble on flush/redirect, hold on stall
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if_id <= IF_ID_BUBBLE;
      pc_d  <= '0;
    end else if (flush | pcsrc) begin
      if_id <= IF_ID_BUBBLE;
      pc_d  <= '0;
    end else if (!stall) begin
      if_id.valid <= 1'b1;
      if_id.instr <= imem_q;
      pc_d        <= pc;
    end
  end

  assign instr_d = if_id.instr;
  assign valid_d = if_id.valid;

  // Count valid loads into IF/ID, saturating at all-ones
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_count <= '0;
    end else if (load_ok && fetch_count != 16'hFFFF) begin
      fetch_count <= fetch_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage.
// Directed table, hand sequences, random run against a model.
import if_stage_pkg::*;

module tb_if_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        flush;
  logic        pcsrc;
  logic [63:0] pcbranch;
  logic [6:0]  imem_addr;
  logic [31:0] imem_q;
  logic [63:0] pc_d;
  logic [31:0] instr_d;
  logic        valid_d;
  logic [15:0] fetch_count;

  logic [31:0] rom [128];

  int checks = 0;
  int errors = 0;

  logic [63:0] m_pc;
  logic [63:0] m_pd;
  logic [31:0] m_ins;
  logic        m_v;
  int          m_cnt;

  typedef struct {
    logic        stall;
    logic        flush;
    logic        pcsrc;
    logic [63:0] br;
    logic [6:0]  addr;
    logic [63:0] pcd;
    logic        v;
    int          idx;
    int          cnt;
  } vec_t;

  vec_t tbl [15];

  if_stage #(.N(64)) dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .flush      (flush),
    .pcsrc      (pcsrc),
    .pcbranch   (pcbranch),
    .imem_addr  (imem_addr),
    .imem_q     (imem_q),
    .pc_d       (pc_d),
    .instr_d    (instr_d),
    .valid_d    (valid_d),
    .fetch_count(fetch_count)
  );

  assign imem_q = rom[imem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic model_reset();
    m_pc  = 64'd0;
    m_pd  = 64'd0;
    m_ins = NOP_INSTR;
    m_v   = 1'b0;
    m_cnt = 0;
  endtask

  task automatic model_edge();
    logic [63:0] npc;
    if (pcsrc)      npc = pcbranch & ~64'd3;
    else if (stall) npc = m_pc;
    else            npc = m_pc + 64'd4;
    if (flush || pcsrc) begin
      m_v   = 1'b0;
      m_ins = NOP_INSTR;
      m_pd  = 64'd0;
    end else if (!stall) begin
      m_v   = 1'b1;
      m_ins = rom[(m_pc >> 2) % 128];
      m_pd  = m_pc;
      if (m_cnt < 65535) m_cnt++;
    end
    m_pc = npc;
  endtask

  task automatic cmp_model(string tag);
    chk({tag, "_addr"}, 64'(imem_addr), (m_pc >> 2) % 128);
    chk({tag, "_pc_d"}, pc_d, m_pd);
    chk({tag, "_instr"}, 64'(instr_d), 64'(m_ins));
    chk({tag, "_valid"}, 64'(valid_d), 64'(m_v));
    chk({tag, "_cnt"}, 64'(fetch_count), 64'(m_cnt));
  endtask

  task automatic idle_in();
    stall    = 1'b0;
    flush    = 1'b0;
    pcsrc    = 1'b0;
    pcbranch = 64'd0;
  endtask

  task automatic chk_reset_vals(string tag);
    chk({tag, "_addr"}, 64'(imem_addr), 64'd0);
    chk({tag, "_pc_d"}, pc_d, 64'd0);
    chk({tag, "_instr"}, 64'(instr_d), 64'h8b1f03ff);
    chk({tag, "_valid"}, 64'(valid_d), 64'd0);
    chk({tag, "_cnt"}, 64'(fetch_count), 64'd0);
  endtask

  initial begin
    idle_in();
    reset = 1'b1;
    for (int i = 0; i < 128; i++) rom[i] = 32'hA5000000 | 32'(i);
    rom[0] = 32'hf8000001;

    tbl[0]  = '{0, 0, 0, 64'h0,   7'd1,   64'h0,   1, 0,   1};
    tbl[1]  = '{0, 0, 0, 64'h0,   7'd2,   64'h4,   1, 1,   2};
    tbl[2]  = '{1, 0, 0, 64'h0,   7'd2,   64'h4,   1, 1,   2};
    tbl[3]  = '{1, 0, 0, 64'h0,   7'd2,   64'h4,   1, 1,   2};
    tbl[4]  = '{0, 0, 0, 64'h0,   7'd3,   64'h8,   1, 2,   3};
    tbl[5]  = '{0, 0, 0, 64'h0,   7'd4,   64'hC,   1, 3,   4};
    tbl[6]  = '{0, 1, 0, 64'h0,   7'd5,   64'h0,   0, 0,   4};
    tbl[7]  = '{0, 0, 0, 64'h0,   7'd6,   64'h14,  1, 5,   5};
    tbl[8]  = '{1, 0, 1, 64'h43,  7'h10,  64'h0,   0, 0,   5};
    tbl[9]  = '{0, 0, 0, 64'h0,   7'h11,  64'h40,  1, 16,  6};
    tbl[10] = '{0, 0, 1, 64'h1FC, 7'd127, 64'h0,   0, 0,   6};
    tbl[11] = '{0, 0, 0, 64'h0,   7'd0,   64'h1FC, 1, 127, 7};
    tbl[12] = '{0, 0, 0, 64'h0,   7'd1,   64'h200, 1, 0,   8};
    tbl[13] = '{1, 1, 0, 64'h0,   7'd1,   64'h0,   0, 0,   8};
    tbl[14] = '{0, 0, 0, 64'h0,   7'd2,   64'h204, 1, 1,   9};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_vals("rst");
    reset = 1'b0;

    chk("pre_addr", 64'(imem_addr), 64'd0);
    for (int i = 0; i < 15; i++) begin
      stall    = tbl[i].stall;
      flush    = tbl[i].flush;
      pcsrc    = tbl[i].pcsrc;
      pcbranch = tbl[i].br;
      tick();
      chk($sformatf("t%0d_addr", i), 64'(imem_addr), 64'(tbl[i].addr));
      chk($sformatf("t%0d_pc_d", i), pc_d, tbl[i].pcd);
      chk($sformatf("t%0d_valid", i), 64'(valid_d), 64'(tbl[i].v));
      chk($sformatf("t%0d_instr", i), 64'(instr_d),
          tbl[i].v ? 64'(rom[tbl[i].idx]) : 64'h8b1f03ff);
      chk($sformatf("t%0d_cnt", i), 64'(fetch_count), 64'(tbl[i].cnt));
    end

    idle_in();
    pcsrc    = 1'b1;
    pcbranch = 64'h80;
    #2 reset = 1'b1;
    #1 chk_reset_vals("async");
    idle_in();
    @(posedge clk);
    chk_reset_vals("held");
    @(negedge clk);
    reset = 1'b0;
    tick();
    chk("rel_addr", 64'(imem_addr), 64'd1);
    chk("rel_pc_d", pc_d, 64'd0);
    chk("rel_instr", 64'(instr_d), 64'hf8000001);
    chk("rel_valid", 64'(valid_d), 64'd1);
    chk("rel_cnt", 64'(fetch_count), 64'd1);

    reset = 1'b1;
    for (int i = 0; i < 128; i++) rom[i] = $urandom;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      stall    = ($urandom_range(0, 3) == 0);
      flush    = ($urandom_range(0, 9) == 0);
      pcsrc    = ($urandom_range(0, 9) == 0);
      pcbranch = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) pcbranch[63:9] = '1;
      model_edge();
      tick();
      cmp_model("rnd");
    end

    idle_in();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    for (int c = 0; c < 65534; c++) begin
      model_edge();
      @(posedge clk);
    end
    @(negedge clk);
    chk("sat_pre", 64'(fetch_count), 64'd65534);
    cmp_model("satp");
    for (int c = 0; c < 3; c++) begin
      model_edge();
      tick();
      chk($sformatf("sat%0d", c), 64'(fetch_count), 64'hFFFF);
      cmp_model("sat");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL declare parameter N, default 64, datapath and PC width in bits.
REQ-002 SHALL declare port clk, input, 1, single system clock; all state updates on its rising edge.
REQ-003 SHALL declare port reset, input, 1, asynchronous, active-high.
REQ-004 SHALL declare port stall, input, 1, hold PC and IF/ID contents.
REQ-005 SHALL declare port flush, input, 1, replace the IF/ID contents with a bubble.
REQ-006 SHALL declare port pcsrc, input, 1, taken-branch redirect request.
REQ-007 SHALL declare port pcbranch, input, N, branch target byte address.
REQ-008 SHALL declare port imem_addr, output, 7, word address to the instruction ROM (128 words).
REQ-009 SHALL declare port imem_q, input, 32, instruction word returned combinationally by the ROM.
REQ-010 SHALL declare port pc_d, output, N, PC of the instruction held in IF/ID.
REQ-011 SHALL declare port instr_d, output, 32, instruction held in IF/ID.
REQ-012 SHALL declare port valid_d, output, 1, asserted when instr_d is a real fetched instruction.
REQ-013 SHALL declare port fetch_count, output, 16, number of valid instructions loaded into IF/ID.

Function
REQ-014 SHALL drive imem_addr combinationally from PC[8:2], so addresses wrap modulo 128 words.
REQ-015 SHALL select the next PC by priority:
- pcsrc=1: pcbranch with bits [1:0] forced to 0.
- else stall=1: PC unchanged.
- else: PC+4, modulo 2^N.
REQ-016 SHALL update the IF/ID register by priority:
- flush=1 or pcsrc=1: instr_d=NOP (32'h8b1f03ff), pc_d=0, valid_d=0.
- else stall=1: hold all IF/ID fields.
- else: instr_d=imem_q, pc_d=PC, valid_d=1.
REQ-017 SHALL give the fetch a latency of one cycle: the word at imem_addr in cycle t appears on instr_d in cycle t+1.
REQ-018 SHALL increment fetch_count only on a clock edge at which valid_d is loaded with 1.
REQ-019 SHALL saturate fetch_count at 16'hFFFF with no wrap.
REQ-020 SHALL, when stall and pcsrc are both asserted, apply the redirect and insert a bubble; the redirect overrides the stall.
REQ-021 SHALL NOT increment fetch_count on a cycle with stall, flush or pcsrc asserted.

Reset
REQ-022 SHALL, while reset is asserted and independent of clk, force: PC=0, pc_d=0, instr_d=NOP, valid_d=0, fetch_count=0.
REQ-023 SHALL abandon any in-flight redirect when reset is asserted mid-operation.
REQ-024 SHALL present imem_addr=0 during reset.
REQ-025 SHALL, on the first rising edge after reset deassertion with no stall, flush or pcsrc, load ROM[0] into IF/ID with valid_d=1.

Structure
REQ-026 SHALL place the following in a shared package, with the IF/ID field layout held as a packed struct there:
- NOP_INSTR = 32'h8b1f03ff
- IMEM_AW = 7
- INSTR_W = 32
REQ-027 SHALL implement the PC as one sub-module, pc_reg, an N-bit register with asynchronous reset, enable and load.
REQ-028 SHALL implement next-PC selection, the IF/ID register and the counter inline.

Verification
REQ-029 SHALL cover reset: assert reset with ROM[0]=32'hf8000001, then release -> during reset imem_addr=0, instr_d=8b1f03ff, valid_d=0; first edge after release gives instr_d=f8000001, pc_d=0, valid_d=1.
REQ-030 SHALL cover sequential fetch: 4 free cycles -> imem_addr 0,1,2,3; pc_d 0,4,8,C one cycle later; fetch_count=4.
REQ-031 SHALL cover stall: assert stall 2 cycles at PC=8 -> imem_addr stays 2; instr_d and pc_d hold; fetch_count unchanged.
REQ-032 SHALL cover redirect overriding stall: pcsrc=1, pcbranch=0x43, stall=1 -> PC=0x40, imem_addr=0x10, IF/ID bubble (valid_d=0); next cycle instr_d=ROM[16], pc_d=0x40.
REQ-033 SHALL cover wrap: PC=0x1FC -> imem_addr=127; next PC=0x200 gives imem_addr=0.
REQ-034 SHALL cover saturation: preload 65534 fetches, then 3 free cycles -> fetch_count holds at FFFF.
